// File: rtl/calc_pkg.sv
// Shared arithmetic-unit definitions: op codes, display limits, converter
// states and active-low 7-segment constants.
package calc_pkg;

   localparam int IN_W   = 40;
   localparam int DIGITS = 6;
   localparam int CONV_W = 20;
   localparam int CNT_W  = $clog2(CONV_W + 1);

   localparam logic [CONV_W-1:0] MAX_POS = 20'd999999;
   // One display digit is given up to the minus sign.
   localparam logic [CONV_W-1:0] MAX_NEG = 20'd99999;

   typedef enum logic [1:0] {
      ADD      = 2'd0,
      MINUS    = 2'd1,
      MULTIPLE = 2'd2,
      DIVIDE   = 2'd3
   } op_e;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      SHIFT,
      ERR,
      DONE
   } conv_state_e;

   // Segment order {g,f,e,d,c,b,a}, active low.
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_MINUS = 7'h3F;
   localparam logic [6:0] SEG_E     = 7'h06;
   localparam logic [6:0] SEG_R     = 7'h2F;

   function automatic logic [3:0] add3(input logic [3:0] d);
      return (d >= 4'd5) ? d + 4'd3 : d;
   endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD nibble to active-low 7-segment pattern {g,f,e,d,c,b,a}.
module bcd_to_seg
   import calc_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      unique case (bcd)
         4'd0:    seg = 7'h40;
         4'd1:    seg = 7'h79;
         4'd2:    seg = 7'h24;
         4'd3:    seg = 7'h30;
         4'd4:    seg = 7'h19;
         4'd5:    seg = 7'h12;
         4'd6:    seg = 7'h02;
         4'd7:    seg = 7'h78;
         4'd8:    seg = 7'h00;
         4'd9:    seg = 7'h10;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/result_bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter with blanking, minus sign
// placement and error display. Define RESULT_SEG_DECODE_EN to add o_seg.
module result_bcd_converter
   import calc_pkg::*;
(
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_start,
   input  logic [IN_W-1:0]       i_result,
   input  logic                  i_sign,
   input  logic                  i_err,
   output logic                  o_busy,
   output logic                  o_done,
   output logic [4*DIGITS-1:0]   o_bcd,
   output logic [DIGITS-1:0]     o_blank,
   output logic [DIGITS-1:0]     o_minus,
   output logic                  o_err
`ifdef RESULT_SEG_DECODE_EN
   ,output logic [7*DIGITS-1:0]  o_seg
`endif
);

   conv_state_e          state;
   logic [IN_W-1:0]      res_q;
   logic                 sign_q;
   logic                 fault_q;
   logic [CONV_W-1:0]    sh_q;
   logic [4*DIGITS-1:0]  acc_q;
   logic [CNT_W-1:0]     cnt_q;

   logic [CONV_W-1:0]    mag;
   logic                 out_of_range;
   logic [4*DIGITS-1:0]  acc_adj;
   logic [DIGITS-1:0]    blank;
   logic [DIGITS-1:0]    minus;

   assign mag = res_q[CONV_W-1:0];

   always_comb begin
      out_of_range = fault_q
                  || (|res_q[IN_W-1:CONV_W])
                  || (sign_q  && (mag > MAX_NEG))
                  || (!sign_q && (mag > MAX_POS));
   end

   // NOTE: every always_comb output gets a full default before any loop or
   // branch, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      acc_adj = '0;
      for (int i = 0; i < DIGITS; i++)
         acc_adj[4*i +: 4] = add3(acc_q[4*i +: 4]);
   end

   // Blank from the top down; digit 0 always shows so zero reads "0".
   always_comb begin
      blank = '0;
      blank[DIGITS-1] = (acc_q[4*DIGITS-1 -: 4] == 4'd0);
      for (int i = DIGITS-2; i >= 1; i--)
         blank[i] = blank[i+1] && (acc_q[4*i +: 4] == 4'd0);
      blank[0] = 1'b0;
   end

   // Minus sits in the first blanked digit above the leading digit.
   always_comb begin
      minus = '0;
      if (sign_q && (acc_q != '0))
         for (int i = 1; i < DIGITS; i++)
            minus[i] = blank[i] && !blank[i-1];
   end

`ifdef RESULT_SEG_DECODE_EN
   logic [6:0] raw_seg  [DIGITS];
   logic [7*DIGITS-1:0] seg_next;

   for (genvar g = 0; g < DIGITS; g++) begin : g_seg
      bcd_to_seg u_bcd_to_seg (
         .bcd (acc_q[4*g +: 4]),
         .seg (raw_seg[g])
      );
   end

   always_comb begin
      seg_next = {DIGITS{SEG_BLANK}};
      for (int i = 0; i < DIGITS; i++) begin
         if (fault_q)
            seg_next[7*i +: 7] = (i == 0) ? SEG_E : (i <= 2) ? SEG_R : SEG_BLANK;
         else if (minus[i])
            seg_next[7*i +: 7] = SEG_MINUS;
         else if (blank[i])
            seg_next[7*i +: 7] = SEG_BLANK;
         else
            seg_next[7*i +: 7] = raw_seg[i];
      end
   end
`endif

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state   <= IDLE;
         res_q   <= '0;
         sign_q  <= 1'b0;
         fault_q <= 1'b0;
         sh_q    <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         o_busy  <= 1'b0;
         o_done  <= 1'b0;
         o_bcd   <= '0;
         o_blank <= '0;
         o_minus <= '0;
         o_err   <= 1'b0;
`ifdef RESULT_SEG_DECODE_EN
         o_seg   <= '0;
`endif
      end else begin
         o_done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (i_start) begin
                  res_q   <= i_result;
                  sign_q  <= i_sign;
                  fault_q <= i_err;
                  o_busy  <= 1'b1;
                  state   <= CHECK;
               end
            end
            CHECK: begin
               fault_q <= out_of_range;
               if (out_of_range) begin
                  state <= ERR;
               end else begin
                  acc_q <= '0;
                  sh_q  <= mag;
                  cnt_q <= CNT_W'(CONV_W);
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               acc_q <= {acc_adj[4*DIGITS-2:0], sh_q[CONV_W-1]};
               sh_q  <= sh_q << 1;
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == CNT_W'(1))
                  state <= DONE;
            end
            ERR: begin
               state <= DONE;
            end
            DONE: begin
               o_done <= 1'b1;
               o_busy <= 1'b0;
               if (fault_q) begin
                  o_err   <= 1'b1;
                  o_bcd   <= '0;
                  o_blank <= '1;
                  o_minus <= '0;
               end else begin
                  o_err   <= 1'b0;
                  o_bcd   <= acc_q;
                  o_blank <= blank;
                  o_minus <= minus;
               end
`ifdef RESULT_SEG_DECODE_EN
               o_seg <= seg_next;
`endif
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_result_bcd_converter.sv
// Directed self-checking bench for result_bcd_converter; checks the o_seg
// patterns too when RESULT_SEG_DECODE_EN is defined.
module tb_result_bcd_converter;
   import calc_pkg::*;

   logic                 i_clk = 1'b0;
   logic                 i_reset = 1'b1;
   logic                 i_start = 1'b0;
   logic [IN_W-1:0]      i_result = '0;
   logic                 i_sign = 1'b0;
   logic                 i_err = 1'b0;
   logic                 o_busy;
   logic                 o_done;
   logic [4*DIGITS-1:0]  o_bcd;
   logic [DIGITS-1:0]    o_blank;
   logic [DIGITS-1:0]    o_minus;
   logic                 o_err;
`ifdef RESULT_SEG_DECODE_EN
   logic [7*DIGITS-1:0]  o_seg;
`endif

   int checks   = 0;
   int failures = 0;
   int lat;

   result_bcd_converter dut (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_start  (i_start),
      .i_result (i_result),
      .i_sign   (i_sign),
      .i_err    (i_err),
      .o_busy   (o_busy),
      .o_done   (o_done),
      .o_bcd    (o_bcd),
      .o_blank  (o_blank),
      .o_minus  (o_minus),
      .o_err    (o_err)
`ifdef RESULT_SEG_DECODE_EN
      ,.o_seg   (o_seg)
`endif
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Pulse start for one edge, then wait (bounded) for o_done; lat = edges after N, -1 on timeout.
   task automatic run_conv(input logic [IN_W-1:0] val, input logic sg, input logic er);
      @(negedge i_clk);
      i_result = val;
      i_sign   = sg;
      i_err    = er;
      i_start  = 1'b1;
      @(posedge i_clk);
      #1 i_start = 1'b0;
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge i_clk);
         #1;
         if (o_done) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic expect_out(input string tag, input int exp_lat, input logic [23:0] bcd,
                             input logic [5:0] blank, input logic [5:0] minus, input logic err);
      check({tag, "_lat"},   64'(lat), 64'(exp_lat));
      check({tag, "_bcd"},   o_bcd,   bcd);
      check({tag, "_blank"}, o_blank, blank);
      check({tag, "_minus"}, o_minus, minus);
      check({tag, "_err"},   o_err,   err);
      check({tag, "_busy"},  o_busy,  1'b0);
   endtask

   int done_cnt;
   logic [23:0] bcd_at_done;

   initial begin
      // Reset state
      repeat (2) @(posedge i_clk);
      #1;
      check("rst_busy",  o_busy,  1'b0);
      check("rst_done",  o_done,  1'b0);
      check("rst_bcd",   o_bcd,   24'h0);
      check("rst_blank", o_blank, 6'h0);
      check("rst_minus", o_minus, 6'h0);
      check("rst_err",   o_err,   1'b0);
      @(negedge i_clk);
      i_reset = 1'b0;

      run_conv(40'd123456, 1'b0, 1'b0);
      expect_out("p123456", 22, 24'h123456, 6'b000000, 6'b000000, 1'b0);
      @(posedge i_clk); #1;
      check("done_pulse", o_done, 1'b0);
      check("hold_bcd",   o_bcd,  24'h123456);

      run_conv(40'd0, 1'b0, 1'b0);
      expect_out("zero", 22, 24'h000000, 6'b111110, 6'b000000, 1'b0);

      run_conv(40'd999999, 1'b0, 1'b0);
      expect_out("maxpos", 22, 24'h999999, 6'b000000, 6'b000000, 1'b0);

      run_conv(40'd4321, 1'b1, 1'b0);
      expect_out("neg4321", 22, 24'h004321, 6'b110000, 6'b010000, 1'b0);
`ifdef RESULT_SEG_DECODE_EN
      check("seg_d0", o_seg[6:0],   7'h79);
      check("seg_d1", o_seg[13:7],  7'h24);
      check("seg_d2", o_seg[20:14], 7'h30);
      check("seg_d3", o_seg[27:21], 7'h19);
      check("seg_minus", o_seg[34:28], 7'h3F);
      check("seg_blank", o_seg[41:35], 7'h7F);
`endif

      run_conv(40'd99999, 1'b1, 1'b0);
      expect_out("maxneg", 22, 24'h099999, 6'b100000, 6'b100000, 1'b0);

      run_conv(40'd5, 1'b1, 1'b0);
      expect_out("neg5", 22, 24'h000005, 6'b111110, 6'b000010, 1'b0);

      run_conv(40'd0, 1'b1, 1'b0);
      expect_out("negzero", 22, 24'h000000, 6'b111110, 6'b000000, 1'b0);

      run_conv(40'd100000, 1'b1, 1'b0);
      expect_out("neg_ovf", 3, 24'h000000, 6'b111111, 6'b000000, 1'b1);
`ifdef RESULT_SEG_DECODE_EN
      check("err_seg", o_seg, {7'h7F, 7'h7F, 7'h7F, 7'h2F, 7'h2F, 7'h06});
`endif

      run_conv(40'd1000000, 1'b0, 1'b0);
      expect_out("pos_ovf", 3, 24'h000000, 6'b111111, 6'b000000, 1'b1);

      run_conv(40'd5, 1'b0, 1'b1);
      expect_out("in_err", 3, 24'h000000, 6'b111111, 6'b000000, 1'b1);

      run_conv(40'h80_0000_0005, 1'b0, 1'b0);
      expect_out("bit39", 3, 24'h000000, 6'b111111, 6'b000000, 1'b1);

      // Restart during busy ignored; input change mid-conversion ignored
      @(negedge i_clk);
      i_result = 40'd777;
      i_sign   = 1'b0;
      i_err    = 1'b0;
      i_start  = 1'b1;
      @(posedge i_clk);
      #1 i_start = 1'b0;
      done_cnt    = 0;
      lat         = -1;
      bcd_at_done = '0;
      for (int k = 1; k <= 40; k++) begin
         if (k == 5) begin
            i_start  = 1'b1;
            i_result = 40'd555;
         end
         @(posedge i_clk);
         #1;
         if (k == 5) i_start = 1'b0;
         if (o_done) begin
            done_cnt++;
            if (lat < 0) lat = k;
            bcd_at_done = o_bcd;
         end
      end
      check("busy_ign_cnt", 64'(done_cnt), 64'd1);
      check("busy_ign_lat", 64'(lat), 64'd22);
      check("busy_ign_bcd", bcd_at_done, 24'h000777);

      // Reset mid-conversion aborts and clears immediately
      @(negedge i_clk);
      i_result = 40'd123456;
      i_start  = 1'b1;
      @(posedge i_clk);
      #1 i_start = 1'b0;
      repeat (9) @(posedge i_clk);
      #1;
      check("mid_busy", o_busy, 1'b1);
      i_reset = 1'b1;
      #1;
      check("abort_busy",  o_busy,  1'b0);
      check("abort_bcd",   o_bcd,   24'h0);
      check("abort_blank", o_blank, 6'h0);
      check("abort_minus", o_minus, 6'h0);
      check("abort_err",   o_err,   1'b0);
      check("abort_done",  o_done,  1'b0);
      @(negedge i_clk);
      i_reset = 1'b0;
      done_cnt = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge i_clk);
         #1;
         if (o_done) done_cnt++;
      end
      check("abort_no_done", 64'(done_cnt), 64'd0);

      run_conv(40'd654321, 1'b0, 1'b0);
      expect_out("after_rst", 22, 24'h654321, 6'b000000, 6'b000000, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
